// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared types and defaults for the register write arbiter
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;

    // Grant index width; never narrower than one bit.
    function automatic int arb_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/register bundle between requesters and the write arbiter
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
);
    localparam int IW = arb_iw(N_REQ);

    logic [N_REQ-1:0]    REQ;
    logic [N_REQ*DW-1:0] REQ_D;
    logic [N_REQ-1:0]    ACK;
    logic                REG_LOAD;
    logic [DW-1:0]       REG_D;
    logic [IW-1:0]       GNT_IDX;
    logic                BUSY;

    modport master (
        output REQ, REQ_D,
        input  ACK, REG_LOAD, REG_D, GNT_IDX, BUSY
    );

    modport slave (
        input  REQ, REQ_D,
        output ACK, REG_LOAD, REG_D, GNT_IDX, BUSY
    );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational rotating-priority picker starting at ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    int idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        valid  = |req;
        winner = '0;
        idx    = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter owning the write path of one shared register
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic               CLK,
    input  logic               CLR_N,
    reg_write_arbiter_if.slave bus
);

    localparam int IW = arb_iw(N_REQ);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_q;
    logic [DW-1:0]    data_q;
    logic [N_REQ-1:0] ack_q;
    logic             load_q;
    logic             busy_q;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [DW-1:0]    win_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (bus.REQ),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign win_data = bus.REQ_D[pick_idx*DW +: DW];

    // data_q doubles as the REG_D register: it holds the winner's data only during LOAD.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            gnt_q  <= '0;
            data_q <= '0;
            ack_q  <= '0;
            load_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state  <= ST_LOAD;
                        gnt_q  <= pick_idx;
                        data_q <= win_data;
                        load_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state  <= ST_DONE;
                    data_q <= '0;
                    load_q <= 1'b0;
                    ack_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    ack_q  <= '0;
                    busy_q <= 1'b0;
                    ptr    <= (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    data_q <= '0;
                    ack_q  <= '0;
                    load_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ACK      = ack_q;
    assign bus.REG_LOAD = load_q;
    assign bus.REG_D    = data_q;
    assign bus.GNT_IDX  = gnt_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic clk;
    logic clr_n;
    int   n_checks;
    int   n_pass;
    int   m_ptr;

    reg_write_arbiter_if #(.N_REQ(4), .DW(8)) u_if ();

    reg_write_arbiter #(.N_REQ(4), .DW(8)) dut (
        .CLK   (clk),
        .CLR_N (clr_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Round-robin rule: first requesting index at or after the pointer, wrapping.
    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(u_if.BUSY), 32'd0);
        chk({tag, "_ack"}, 32'(u_if.ACK), 32'd0);
        chk({tag, "_load"}, 32'(u_if.REG_LOAD), 32'd0);
    endtask

    // Entered and left at a negedge of an IDLE cycle.
    task automatic txn(input logic [3:0] r, input logic [31:0] d, input bit mutate);
        int g;
        logic [3:0] onehot;
        g = rr_winner(r, m_ptr);
        u_if.REQ   = r;
        u_if.REQ_D = d;
        @(negedge clk);
        if (g < 0) begin
            chk_idle("noreq");
            return;
        end
        chk("load_strobe", 32'(u_if.REG_LOAD), 32'd1);
        chk("load_data", 32'(u_if.REG_D), 32'(d[g*8 +: 8]));
        chk("gnt_idx", 32'(u_if.GNT_IDX), 32'(g));
        chk("load_busy", 32'(u_if.BUSY), 32'd1);
        chk("load_ack", 32'(u_if.ACK), 32'd0);
        if (mutate) begin
            u_if.REQ_D[g*8 +: 8] = 8'hFF;
            u_if.REQ[g]          = 1'b0;
        end
        @(negedge clk);
        onehot = 4'b0001 << g;
        chk("done_ack", 32'(u_if.ACK), 32'(onehot));
        chk("done_load", 32'(u_if.REG_LOAD), 32'd0);
        chk("done_busy", 32'(u_if.BUSY), 32'd1);
        @(negedge clk);
        chk_idle("post");
        chk("post_gnt", 32'(u_if.GNT_IDX), 32'(g));
        m_ptr = (g + 1) % 4;
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] d;
        n_checks   = 0;
        n_pass     = 0;
        m_ptr      = 0;
        clr_n      = 1'b0;
        u_if.REQ   = 4'b1111;
        u_if.REQ_D = 32'h13121110;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle("reset");
            chk("reset_regd", 32'(u_if.REG_D), 32'd0);
            chk("reset_gnt", 32'(u_if.GNT_IDX), 32'd0);
        end
        u_if.REQ = 4'b0000;
        clr_n    = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        txn(4'b0100, 32'h00A50000, 1'b0);
        txn(4'b0011, 32'h00002211, 1'b0);
        txn(4'b0011, 32'h00002211, 1'b0);
        txn(4'b0010, 32'h00003C00, 1'b1);

        // Abort during LOAD: no ACK afterwards and the pointer returns to 0.
        u_if.REQ   = 4'b0001;
        u_if.REQ_D = 32'h00000077;
        @(negedge clk);
        chk("abort_load", 32'(u_if.REG_LOAD), 32'd1);
        clr_n    = 1'b0;
        u_if.REQ = 4'b0000;
        @(negedge clk);
        chk_idle("abort");
        chk("abort_gnt", 32'(u_if.GNT_IDX), 32'd0);
        @(negedge clk);
        chk_idle("abort2");
        clr_n = 1'b1;
        m_ptr = 0;
        txn(4'b1111, 32'h44332211, 1'b0);
        txn(4'b1000, 32'h99000000, 1'b0);

        for (int i = 0; i < 5; i++) begin
            txn(4'b1111, 32'h13121110, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom_range(0, 15));
            d = $urandom;
            txn(r, d, 1'($urandom_range(0, 1)));
        end
        u_if.REQ = 4'b0000;
        @(negedge clk);
        chk_idle("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
